// File: rtl/i2c_target.sv
// I2C target endpoint: START/STOP detection, 7-bit address match with ACK,
// MSB-first write reception and read serialization over open-drain SDA.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       addressed,
  output logic       read_mode,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
  } state_t;

  state_t     state;
  logic [3:0] bitcnt;
  logic [7:0] shift;
  logic [7:0] tx_shift;

  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;

  // Two-flop synchronizers plus one history flop for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_s1 <= 1'b0; scl_s2 <= 1'b0; scl_h <= 1'b0;
      sda_s1 <= 1'b0; sda_s2 <= 1'b0; sda_h <= 1'b0;
    end else begin
      scl_s1 <= scl_in; scl_s2 <= scl_s1; scl_h <= scl_s2;
      sda_s1 <= sda_in; sda_s2 <= sda_s1; sda_h <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_ev, stop_ev;

  // Bus events; SCL must be high in both the current and previous sample so
  // the synchronizers filling after reset do not look like a STOP
  always_comb begin
    scl_rise = scl_s2 & ~scl_h;
    scl_fall = ~scl_s2 & scl_h;
    start_ev = ~sda_s2 & sda_h & scl_s2 & scl_h;
    stop_ev  = sda_s2 & ~sda_h & scl_s2 & scl_h;
  end

  // Protocol FSM with registered outputs; STOP/START override bit actions
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shift     <= '0;
      tx_shift  <= '0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      addressed <= 1'b0;
      read_mode <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      stop_det <= 1'b0;
      if (stop_ev) begin
        state     <= IDLE;
        bitcnt    <= '0;
        sda_oe    <= 1'b0;
        addressed <= 1'b0;
        stop_det  <= 1'b1;
      end else if (start_ev) begin
        state     <= ADDR;
        bitcnt    <= '0;
        sda_oe    <= 1'b0;
        addressed <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise && bitcnt != 4'd8) begin
              shift  <= {shift[6:0], sda_s2};
              bitcnt <= bitcnt + 4'd1;
            end
            if (scl_fall && bitcnt == 4'd8) begin
              if (shift[7:1] == TARGET_ADDR) begin
                sda_oe    <= 1'b1;
                read_mode <= shift[0];
                addressed <= 1'b1;
                tx_req    <= shift[0];
                state     <= ADDR_ACK;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_rise && read_mode) tx_shift <= tx_data;
            if (scl_fall) begin
              bitcnt <= '0;
              if (read_mode) begin
                sda_oe <= ~tx_shift[7];
                state  <= READ;
              end else begin
                sda_oe <= 1'b0;
                state  <= WRITE;
              end
            end
          end
          WRITE: begin
            if (scl_rise && bitcnt != 4'd8) begin
              shift  <= {shift[6:0], sda_s2};
              bitcnt <= bitcnt + 4'd1;
            end
            if (scl_fall && bitcnt == 4'd8) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              sda_oe   <= 1'b1;
              state    <= WRITE_ACK;
            end
          end
          WRITE_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              bitcnt <= '0;
              state  <= WRITE;
            end
          end
          READ: begin
            // bitcnt counts bits already completed; MSB was driven on entry
            if (scl_fall) begin
              if (bitcnt == 4'd7) begin
                sda_oe <= 1'b0;
                tx_req <= 1'b1;
                bitcnt <= '0;
                state  <= READ_ACK;
              end else begin
                tx_shift <= {tx_shift[6:0], 1'b0};
                sda_oe   <= ~tx_shift[6];
                bitcnt   <= bitcnt + 4'd1;
              end
            end
          end
          READ_ACK: begin
            if (scl_rise) begin
              if (!sda_s2) begin
                tx_shift <= tx_data;
              end else begin
                addressed <= 1'b0;
                state     <= IGNORE;
              end
            end else if (scl_fall) begin
              sda_oe <= ~tx_shift[7];
              bitcnt <= '0;
              state  <= READ;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
